// File: rtl/ysyx_24090013_pkg.sv
// Shared constants and types for the ysyx_24090013 instruction fetch memory.
package ysyx_24090013_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;
  localparam int          LATENCY_MIN   = 1;
  localparam int          LATENCY_MAX   = 4;
  localparam int          ERR_CNT_W     = 8;
  localparam int          FETCH_DATA_W  = 32;

  typedef struct packed {
    logic                    err;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ysyx_24090013_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; flush empties it and drops a coincident push.
module ysyx_24090013_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop_s;

  assign do_pop_s = pop_i && !empty_o;
  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  assign rdata_o  = mem_q[rd_ptr_q];

  always_comb begin
    case ({push_i, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage is unreset: only entries covered by a nonzero count are ever read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ysyx_24090013_inst_mem_ctrl.sv
// Instruction memory front end: decodes fetch addresses against a flattened image and returns
// words strictly in order through a fixed-latency pipeline and a credit-limited response FIFO.
module ysyx_24090013_inst_mem_ctrl
  import ysyx_24090013_pkg::*;
#(
  parameter int                DATA_W     = FETCH_DATA_W,
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH      = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(BASE_ADDR_DEF),
  parameter int                LATENCY    = 1,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DEPTH*DATA_W-1:0] init_image,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic                    flush,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [ERR_CNT_W-1:0]    err_cnt
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OUT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = DATA_W + 1;

  logic [DATA_W-1:0]    words_s [DEPTH];
  logic [ADDR_W-1:0]    idx_s;
  logic                 addr_err_s, accept_s, pop_s, fifo_push_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [ENT_W-1:0]     entry_s, fifo_head_s;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    assign words_s[w] = init_image[w*DATA_W +: DATA_W];
  end

  // Addresses below BASE_ADDR wrap to a huge index and fall out of range.
  assign idx_s      = (req_addr - BASE_ADDR) >> 2;
  assign addr_err_s = (req_addr[1:0] != 2'b00) || (idx_s >= ADDR_W'(DEPTH));
  assign entry_s    = addr_err_s ? {1'b1, {DATA_W{1'b0}}}
                                 : {1'b0, words_s[idx_s[IDX_W-1:0]]};

  assign req_ready = rst && !flush && (outstanding_q < OUT_W'(FIFO_DEPTH));
  assign accept_s  = req_valid && req_ready;
  assign pop_s     = rsp_valid && rsp_ready;

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    logic             vld_in_s, vld_q;
    logic [ENT_W-1:0] ent_in_s, ent_q;
    if (s == 0) begin : g_head
      assign vld_in_s = accept_s;
      assign ent_in_s = entry_s;
    end else begin : g_link
      assign vld_in_s = g_stage[s-1].vld_q;
      assign ent_in_s = g_stage[s-1].ent_q;
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= 1'b0;
        ent_q <= '0;
      end else begin
        vld_q <= vld_in_s && !flush;
        ent_q <= ent_in_s;
      end
    end
  end

  // Credits make a push into a full FIFO impossible; the guard only keeps the FIFO consistent.
  assign fifo_push_s = g_stage[LATENCY-1].vld_q && (!fifo_full_s || pop_s);

  ysyx_24090013_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (flush),
    .push_i  (fifo_push_s),
    .wdata_i (entry_from_pipe()),
    .pop_i   (pop_s),
    .rdata_o (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  function automatic logic [ENT_W-1:0] entry_from_pipe();
    return g_stage[LATENCY-1].ent_q;
  endfunction

  always_comb begin
    case ({accept_s, pop_s})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_q <= '0;
      err_cnt_q     <= '0;
    end else begin
      outstanding_q <= flush ? '0 : outstanding_d;
      if (pop_s && fifo_head_s[DATA_W]) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign rsp_valid = !fifo_empty_s;
  assign rsp_data  = rsp_valid ? fifo_head_s[DATA_W-1:0] : '0;
  assign rsp_err   = rsp_valid && fifo_head_s[DATA_W];
  assign busy      = (outstanding_q != '0);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ysyx_24090013_inst_mem_ctrl.sv
// Scoreboard bench: one DUT per legal LATENCY, each driven by the same directed sequence;
// accepted fetches queue their expected response and a monitor checks responses in order.
module tb_ysyx_24090013_inst_mem_ctrl;
  import ysyx_24090013_pkg::*;

  localparam int DEPTH  = 20;
  localparam int N_INST = LATENCY_MAX - LATENCY_MIN + 1;

  typedef struct {
    fetch_entry_t ent;
    int           acc;
    bit           chk;
  } exp_t;

  logic              clk = 1'b0;
  int                cyc = 0;
  int                vectors = 0;
  int                miscompares = 0;
  int                n_done = 0;
  logic [DEPTH*32-1:0] image;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word i = {i, A5, ~i, 5A}, e.g. word 4 = 32'h04A5_FB5A, word 19 = 32'h13A5_EC5A.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_img
    assign image[gi*32 +: 32] = {8'(gi), 8'hA5, ~8'(gi), 8'h5A};
  end

  task automatic check(input string name, input int lat, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (L=%0d): got %0h expected %0h", name, lat, act, exp);
    end
  endtask

  for (genvar gl = LATENCY_MIN; gl <= LATENCY_MAX; gl++) begin : g_lat
    logic                 rst, req_valid, req_ready, flush;
    logic                 rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0]          req_addr, rsp_data;
    logic [ERR_CNT_W-1:0] err_cnt;
    exp_t                 exp_q[$];

    ysyx_24090013_inst_mem_ctrl #(.LATENCY(gl)) dut (
      .clk        (clk),
      .rst        (rst),
      .init_image (image),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .flush      (flush),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .err_cnt    (err_cnt)
    );

    always @(negedge clk) begin
      if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        exp_t e;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_rsp (L=%0d): got data %h err %b, expected no response", gl, rsp_data, rsp_err);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", gl, 64'(rsp_data), 64'(e.ent.data));
          check("rsp_err", gl, 64'(rsp_err), 64'(e.ent.err));
          if (e.chk) check("rsp_latency", gl, 64'(cyc - e.acc), 64'(gl));
        end
      end
    end

    task automatic push_exp(input logic e_err, input logic [31:0] e_data, input bit chk);
      exp_t e;
      e.ent.err  = e_err;
      e.ent.data = e_data;
      e.acc      = cyc + 1;
      e.chk      = chk;
      exp_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic e_err, input logic [31:0] e_data, input bit chk);
      int w;
      w = 0;
      req_valid = 1'b1;
      req_addr  = a;
      @(negedge clk);
      while (req_ready !== 1'b1 && w < 100) begin
        w++;
        @(negedge clk);
      end
      if (req_ready === 1'b1) begin
        push_exp(e_err, e_data, chk);
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout (L=%0d): addr %h never accepted", gl, a);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    endtask

    task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (exp_q.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL drain_timeout (L=%0d): %0d responses missing", gl, exp_q.size());
        exp_q.delete();
      end
      @(posedge clk); #1;
    endtask

    initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0; rsp_ready = 1'b0;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", gl, 64'(req_ready), 64'(0));
      check("rst_rsp_valid", gl, 64'(rsp_valid), 64'(0));
      check("rst_rsp_data", gl, 64'(rsp_data), 64'(0));
      check("rst_rsp_err", gl, 64'(rsp_err), 64'(0));
      check("rst_busy", gl, 64'(busy), 64'(0));
      check("rst_err_cnt", gl, 64'(err_cnt), 64'(0));
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", gl, 64'(req_ready), 64'(1));
      @(posedge clk); #1;
      rsp_ready = 1'b1;

      // Streaming, in order.
      issue(32'h8000_0000, 1'b0, 32'h00A5_FF5A, 1'b1);
      issue(32'h8000_0004, 1'b0, 32'h01A5_FE5A, 1'b1);
      issue(32'h8000_0008, 1'b0, 32'h02A5_FD5A, 1'b1);
      drain();

      // Misaligned, one past the end, below base, then the last valid word.
      issue(32'h8000_0002, 1'b1, 32'h0, 1'b1);
      issue(32'h8000_0050, 1'b1, 32'h0, 1'b1);
      issue(32'h7FFF_FFFC, 1'b1, 32'h0, 1'b1);
      issue(32'h8000_004C, 1'b0, 32'h13A5_EC5A, 1'b1);
      drain();
      @(negedge clk);
      check("err_cnt_after_3", gl, 64'(err_cnt), 64'(3));

      // Backpressure: two credits, third request held until the credit of a pop returns.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      issue(32'h8000_000C, 1'b0, 32'h03A5_FC5A, 1'b0);
      issue(32'h8000_0010, 1'b0, 32'h04A5_FB5A, 1'b0);
      req_valid = 1'b1;
      req_addr  = 32'h8000_0014;
      for (int i = 0; i < gl + 3; i++) begin
        @(negedge clk);
        check("bp_req_ready", gl, 64'(req_ready), 64'(0));
        check("bp_busy", gl, 64'(busy), 64'(1));
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_credit_not_early", gl, 64'(req_ready), 64'(0));
      @(negedge clk);
      check("bp_credit_returned", gl, 64'(req_ready), 64'(1));
      push_exp(1'b0, 32'h05A5_FA5A, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      drain();

      // Flush with two fetches in flight; a request during the flush cycle is held off.
      issue(32'h8000_0020, 1'b0, 32'h08A5_F75A, 1'b1);
      issue(32'h8000_0024, 1'b0, 32'h09A5_F65A, 1'b1);
      flush     = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h8000_0010;
      @(negedge clk);
      check("flush_req_ready", gl, 64'(req_ready), 64'(0));
      @(posedge clk); #1;
      flush = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("post_flush_rsp_valid", gl, 64'(rsp_valid), 64'(0));
      check("post_flush_busy", gl, 64'(busy), 64'(0));
      check("post_flush_req_ready", gl, 64'(req_ready), 64'(1));
      push_exp(1'b0, 32'h04A5_FB5A, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      drain();

      // Saturation: 300 more error fetches.
      for (int i = 0; i < 300; i++) begin
        issue(((i % 2) == 0) ? 32'h9000_0000 : 32'h8000_0001, 1'b1, 32'h0, 1'b1);
      end
      drain();
      @(negedge clk);
      check("err_cnt_saturated", gl, 64'(err_cnt), 64'(8'hFF));

      // Asynchronous reset with two fetches outstanding.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      issue(32'h8000_0000, 1'b0, 32'h00A5_FF5A, 1'b0);
      issue(32'h8000_0004, 1'b0, 32'h01A5_FE5A, 1'b0);
      check("pre_rst_busy", gl, 64'(busy), 64'(1));
      rst = 1'b0;
      #1;
      check("midrst_rsp_valid", gl, 64'(rsp_valid), 64'(0));
      check("midrst_busy", gl, 64'(busy), 64'(0));
      check("midrst_err_cnt", gl, 64'(err_cnt), 64'(0));
      check("midrst_req_ready", gl, 64'(req_ready), 64'(0));
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_release_req_ready", gl, 64'(req_ready), 64'(1));
      check("midrst_release_rsp_valid", gl, 64'(rsp_valid), 64'(0));
      n_done++;
    end
  end

  initial begin
    int w;
    w = 0;
    while (n_done < N_INST && w < 20000) begin
      @(posedge clk);
      w++;
    end
    if (n_done < N_INST) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: %0d of %0d instances finished", n_done, N_INST);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
